cycle_sequencer: RTL and testbench

- Instruction-cycle controller that owns and sequences the CPU T-state counter.
- Runs, halts and single-steps the machine, and ends an instruction early when microcode signals its last T-state.
- Inserts an interrupt-entry instruction at instruction boundaries.
- Sits between the front-panel/run control, the microcode ROM outputs and the control-signal decode that consumes T.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/tstate_counter.sv | 40 ++++
 rtl/cycle_sequencer.sv | 133 +++++++++++++
 tb/tb_cycle_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU sequencing types and sizing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   T_WIDTH  width of the T-state count
//   T_MAX    last legal T-state; the counter wraps to 0 after it
//   FETCH_T  T-states reserved for fetch (T0..FETCH_T-1)
//   state_t  sequencer run state
package cpu_pkg;

  localparam int T_WIDTH = 3;
  localparam int T_MAX   = 7;
  localparam int FETCH_T = 2;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

endpackage

// File: rtl/tstate_counter.sv
// T-state register: falling-edge counter with async clear, sync clear and enable.
// Latency: new value visible after each falling edge of clk.
// Backpressure: none; en simply holds the count.
//
// Ports:
//   clk    system clock (state updates on the falling edge)
//   reset  asynchronous active-high clear
//   clr    synchronous clear to 0 (wins over en)
//   en     advance by one, wrapping to 0 after T_MAX
//   t      current T-state
module tstate_counter #(
  parameter int T_WIDTH = cpu_pkg::T_WIDTH,
  parameter int T_MAX   = cpu_pkg::T_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [T_WIDTH-1:0] t
);

  localparam logic [T_WIDTH-1:0] T_LAST = T_WIDTH'(T_MAX);

  // Wrap is explicit so T never exceeds T_MAX even when T_MAX is not
  // 2**T_WIDTH-1.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      t <= '0;
    end else if (clr) begin
      t <= '0;
    end else if (en) begin
      if (t == T_LAST) begin
        t <= '0;
      end else begin
        t <= t + T_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle controller: run/halt/single-step, early end on t_end, irq entry at boundaries.
// Latency: all state changes on the falling edge; T, in_irq, irq_ack are registered.
// Backpressure: none; run drop only takes effect at the next instruction boundary.
//
// Ports:
//   clk          system clock (falling-edge state updates)
//   reset        asynchronous active-high; HALT, T=0, irq state cleared
//   run          level, free-run enable
//   step         level; a rise seen while halted runs one instruction
//   t_end        microcode: current T-state is the last of this instruction
//   irq          interrupt request (level)
//   irq_en       interrupt enable from CPU state
//   T            current T-state
//   instr_start  high while T==0 and not halted
//   halted       high in HALT
//   in_irq       current instruction is the interrupt-entry sequence
//   irq_ack      one-cycle pulse when an interrupt is accepted
module cycle_sequencer #(
  parameter int T_WIDTH = cpu_pkg::T_WIDTH,
  parameter int T_MAX   = cpu_pkg::T_MAX,
  parameter int FETCH_T = cpu_pkg::FETCH_T
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               t_end,
  input  logic               irq,
  input  logic               irq_en,
  output logic [T_WIDTH-1:0] T,
  output logic               instr_start,
  output logic               halted,
  output logic               in_irq,
  output logic               irq_ack
);

  import cpu_pkg::*;

  localparam logic [T_WIDTH-1:0] T_LAST  = T_WIDTH'(T_MAX);
  localparam logic [T_WIDTH-1:0] T_FETCH = T_WIDTH'(FETCH_T);

  state_t state;
  state_t state_nxt;

  logic step_q;
  logic step_rise;
  logic active;
  logic boundary;
  logic take_irq;
  logic cnt_clr;
  logic cnt_en;

  // Only a rise observed by the HALT state starts a step; rises while
  // executing are not remembered.
  assign step_rise = step & ~step_q;

  assign active = (state == RUN) || (state == STEP);

  // t_end is ignored during fetch. t_end at T_MAX coincides with the
  // natural wrap and still yields exactly one boundary.
  assign boundary = active && ((T == T_LAST) || (t_end && (T >= T_FETCH)));

  // An interrupt-entry instruction cannot itself be interrupted; a request
  // still present is reconsidered at the following boundary.
  assign take_irq = boundary & irq & irq_en & ~in_irq;

  tstate_counter #(
    .T_WIDTH (T_WIDTH),
    .T_MAX   (T_MAX)
  ) u_tcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .t     (T)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state <= HALT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      HALT: begin
        cnt_clr = 1'b1;
        if (run) begin
          state_nxt = RUN;
        end else if (step_rise) begin
          state_nxt = STEP;
        end
      end
      RUN, STEP: begin
        if (boundary) begin
          cnt_clr   = 1'b1;
          state_nxt = run ? RUN : HALT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = HALT;
      end
    endcase
  end

  // in_irq only changes at a boundary, so an entry accepted on the way into
  // HALT is still pending when the machine resumes.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= 1'b0;
      in_irq  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      step_q  <= step;
      irq_ack <= take_irq;
      if (boundary) begin
        in_irq <= take_irq;
      end
    end
  end

  assign halted      = (state == HALT);
  assign instr_start = (T == '0) && !halted;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: vector table, corner sequences, random vs model.
// Latency: outputs sampled 1ns after each rising edge (opposite to the active falling edge).
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_cycle_sequencer;

  localparam int TW   = 3;
  localparam int TMAX = 7;
  localparam int FT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          step;
  logic          t_end;
  logic          irq;
  logic          irq_en;
  logic [TW-1:0] T;
  logic          instr_start;
  logic          halted;
  logic          in_irq;
  logic          irq_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cycle_sequencer #(
    .T_WIDTH (TW),
    .T_MAX   (TMAX),
    .FETCH_T (FT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .t_end       (t_end),
    .irq         (irq),
    .irq_en      (irq_en),
    .T           (T),
    .instr_start (instr_start),
    .halted      (halted),
    .in_irq      (in_irq),
    .irq_ack     (irq_ack)
  );

  typedef struct {
    logic r, s, te, i, ie;
    int   t;
    logic h, st, ii, a;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic s, logic te, logic i, logic ie,
                             int t, logic h, logic st, logic ii, logic a);
    vec_t x;
    x.r = r; x.s = s; x.te = te; x.i = i; x.ie = ie;
    x.t = t; x.h = h; x.st = st; x.ii = ii; x.a = a;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input int h, input int st,
                         input int ii, input int a);
    chk({tag, ".T"},           int'(T),           t);
    chk({tag, ".halted"},      int'(halted),      h);
    chk({tag, ".instr_start"}, int'(instr_start), st);
    chk({tag, ".in_irq"},      int'(in_irq),      ii);
    chk({tag, ".irq_ack"},     int'(irq_ack),     a);
  endtask

  // Apply inputs away from the falling edge, let one falling edge happen,
  // then sample just after the next rising edge.
  task automatic drive(input logic r, input logic s, input logic te,
                       input logic i, input logic ie);
    run = r; step = s; t_end = te; irq = i; irq_en = ie;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Reference model: instruction-level view with plain integers.
  int   m_mode;      // 0 halted, 1 running, 2 single instruction
  int   m_t;
  logic m_irq;
  logic m_ack;
  logic m_step_prev;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_irq = 1'b0; m_ack = 1'b0; m_step_prev = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic te,
                            input logic i, input logic ie);
    logic rise;
    logic last;
    rise = s && !m_step_prev;
    m_step_prev = s;
    m_ack = 1'b0;
    if (m_mode == 0) begin
      m_t = 0;
      if (r) m_mode = 1;
      else if (rise) m_mode = 2;
    end else begin
      last = (m_t == TMAX) || (te && (m_t >= FT));
      if (last) begin
        m_t    = 0;
        m_mode = r ? 1 : 0;
        m_ack  = i && ie && !m_irq;
        m_irq  = m_ack;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; run = 1'b1; step = 1'b0; t_end = 1'b0; irq = 1'b0; irq_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset_held", 0, 1, 0, 0, 0);
    reset = 1'b0;

    // run, t_end, run drop, interrupt entry and blocking
    tbl.push_back(v(1,0,0,0,0, 0,0,1,0,0));
    for (int i = 1; i <= 7; i++) tbl.push_back(v(1,0,0,0,0, i,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(v(1,0,1,0,0, 2,0,0,0,0));   // t_end at T1 ignored
    tbl.push_back(v(1,0,0,0,0, 3,0,0,0,0));
    tbl.push_back(v(1,0,1,0,0, 0,0,1,0,0));   // t_end at T3 ends instruction
    for (int i = 1; i <= 4; i++) tbl.push_back(v(1,0,0,0,0, i,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0,0));   // run dropped at T4
    tbl.push_back(v(0,0,0,0,0, 6,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 7,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(1,0,0,0,0, 0,0,1,0,0));
    for (int i = 1; i <= 5; i++) tbl.push_back(v(1,0,0,0,0, i,0,0,0,0));
    tbl.push_back(v(1,0,0,1,1, 6,0,0,0,0));   // irq raised at T5
    tbl.push_back(v(1,0,0,1,1, 7,0,0,0,0));
    tbl.push_back(v(1,0,0,1,1, 0,0,1,1,1));
    for (int i = 1; i <= 7; i++) tbl.push_back(v(1,0,0,1,1, i,0,0,1,0));
    tbl.push_back(v(1,0,0,1,1, 0,0,1,0,0));   // blocked by in_irq
    tbl.push_back(v(1,0,0,1,1, 1,0,0,0,0));
    tbl.push_back(v(1,0,1,1,1, 2,0,0,0,0));
    tbl.push_back(v(1,0,1,1,1, 0,0,1,1,1));   // re-evaluated at next boundary
    tbl.push_back(v(1,0,1,1,1, 1,0,0,1,0));
    tbl.push_back(v(1,0,1,1,1, 2,0,0,1,0));
    tbl.push_back(v(1,0,1,1,0, 0,0,1,0,0));   // irq_en=0
    tbl.push_back(v(1,0,1,1,0, 1,0,0,0,0));
    tbl.push_back(v(1,0,1,1,0, 2,0,0,0,0));
    tbl.push_back(v(1,0,1,1,0, 0,0,1,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].te, tbl[i].i, tbl[i].ie);
      chk_all($sformatf("row%0d", i), tbl[i].t, int'(tbl[i].h), int'(tbl[i].st),
              int'(tbl[i].ii), int'(tbl[i].a));
    end

    // finish current instruction into HALT
    k = 0;
    while (!halted && k < 16) begin
      drive(0,0,0,0,0);
      k++;
    end
    chk("reach_halt", int'(halted), 1);
    chk("reach_halt.T", int'(T), 0);

    // single step with step held high: exactly one instruction
    drive(0,0,0,0,0);
    drive(0,1,0,0,0);
    chk_all("step0", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      drive(0,1,0,0,0);
      chk_all($sformatf("step_t%0d", i), i, 0, 0, 0, 0);
    end
    drive(0,1,0,0,0);
    chk_all("step_end", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,0,0);
      chk_all($sformatf("step_held%0d", i), 0, 1, 0, 0, 0);
    end

    // step shortened by t_end
    drive(0,0,0,0,0);
    drive(0,1,0,0,0);
    chk_all("step2_0", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0,0,0,0,0);
      chk_all($sformatf("step2_t%0d", i), i, 0, 0, 0, 0);
    end
    drive(0,0,1,0,0);
    chk_all("step2_end", 0, 1, 0, 0, 0);

    // step that ends with run high continues running
    drive(0,1,0,0,0);
    chk_all("step3_0", 0, 0, 1, 0, 0);
    drive(1,0,0,0,0);
    drive(1,0,0,0,0);
    chk_all("step3_t2", 2, 0, 0, 0, 0);
    drive(1,0,1,0,0);
    chk_all("step3_run", 0, 0, 1, 0, 0);
    drive(1,0,0,0,0);
    chk_all("step3_cont", 1, 0, 0, 0, 0);

    // async reset at T6 of an interrupt-entry instruction
    k = 0;
    while (!(in_irq && T == 3'd6) && k < 40) begin
      drive(1,0,0,1,1);
      k++;
    end
    chk("irq_t6_reached", int'(in_irq && T == 3'd6), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 1, 0, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;

    // randomized run against the reference model
    run = 1'b0; step = 1'b0; t_end = 1'b0; irq = 1'b0; irq_en = 1'b0;
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic r, s, te, i, ie;
      r  = run;
      s  = step;
      i  = irq;
      if ($urandom_range(0, 9) == 0) r = ~r;
      if ($urandom_range(0, 3) == 0) s = ~s;
      if ($urandom_range(0, 4) == 0) i = ~i;
      te = ($urandom_range(0, 5) == 0);
      ie = ($urandom_range(0, 9) < 6);
      if (c % 500 == 499) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("rnd_async_reset", 0, 1, 0, 0, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
      end
      drive(r, s, te, i, ie);
      model_edge(r, s, te, i, ie);
      chk_all($sformatf("rnd%0d", c), m_t, int'(m_mode == 0),
              int'(m_t == 0 && m_mode != 0), int'(m_irq), int'(m_ack));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
